rename_stage: RTL and testbench
===============================

// Module: rename_stage
// PURPOSE
//  2-wide register-rename stage directly upstream of dispatch/issue. Maps each decoded
//  instruction's architectural rs1/rs2/rd to physical registers through a RAT and
//  allocates new destination registers from a circular free list. Emits one registered
//  pair per cycle to dispatch. Retire returns superseded physical registers to the free list.
// PARAMETERS
//  NUM_A_REGS  32  architectural registers
//  NUM_P_REGS  64  physical registers; free-list depth = NUM_P_REGS-NUM_A_REGS
//  AW          $clog2(NUM_A_REGS)  architectural index width
//  PW          $clog2(NUM_P_REGS)  physical index width
// PORTS
//  clk_i           in   1      clock, rising edge
//  rst_i           in   1      asynchronous reset, active-high
//  in_valid_i      in   2      slot valid (slot0 older than slot1)
//  in_ready_o      out  1      pair accepted when in_ready_o && |in_valid_i
//  in_rs1_i/rs2_i  in   2xAW   architectural sources per slot
//  in_rd_i         in   2xAW   architectural destination per slot
//  in_regwrite_i   in   2      slot writes rd
//  out_valid_o     out  2      renamed slot valid
//  out_ready_i     in   1      dispatch accepts the pair
//  out_prs1_o/prs2_o out 2xPW  physical sources
//  out_prd_o       out  2xPW   new physical destination (0 if no write)
//  out_old_prd_o   out  2xPW   previous mapping of rd, carried to ROB for retire-free
//  ret_valid_i     in   2      retire frees ret_preg_i per slot
//  ret_preg_i      in   2xPW   physical registers to free
// BEHAVIOUR
//  - Reset (async): RAT[a]=a; free list holds p32..p63 in order, head=0, tail=0, count=32;
//    out_valid_o=0, all out_* data=0. Reset mid-operation discards the registered pair.
//  - in_ready_o = (!|out_valid_o || out_ready_i) && count>=2; no dependence on in_valid_i.
//  - Latency 1: accepted pair appears on out_* next cycle; held stable while out_valid_o
//    && !out_ready_i. Cycle with ready but no input clears out_valid_o.
//  - Allocation: slot needs a preg iff valid && regwrite && rd!=0. Slot0 takes entry[head],
//    slot1 takes next entry (entry[head] if slot0 needs none). head += allocs, mod depth.
//  - rd==0 or !regwrite: prd=0, old_prd=0, RAT unchanged.
//  - Intra-pair bypass: slot1 rs1/rs2 equal to slot0 allocating rd read slot0's new prd;
//    slot1 old_prd likewise is slot0's new prd when rd matches. Same rd both slots: RAT ends
//    with slot1's prd.
//  - Sources with index 0 map to p0 always.
//  - Free: each ret_valid_i slot with ret_preg_i!=0 written at tail, tail += frees.
//    p0 frees ignored. Freed regs not allocatable in the same cycle.
//  - count_next = count - allocs + frees; simultaneous alloc/free both take effect.
//  - Frees beyond depth (count would exceed 32) is a protocol error; simulation assertion.
//  - Pointer wrap: head/tail wrap modulo depth; depth power of two by parameter rule.
// CONFIGURATION
//  RENAME_STATS_EN defined: adds outputs stat_renamed_o (32b, += number of renamed slots
//  per accepted pair) and stat_stall_o (32b, += 1 per cycle with |in_valid_i && !in_ready_o);
//  both reset to 0 and saturate at all-ones. Undefined: ports and counters absent.
// STRUCTURE
//  - Package riscv_pkg: NUM_A_REGS/NUM_P_REGS constants, preg_t/areg_t typedefs,
//    rename_req_t / rename_rsp_t packed structs shared with dispatch_issue.
//  - Sub-module free_list: 2-pop/2-push circular FIFO with count; RAT, bypass and output
//    register remain in rename_stage.
// TESTING
//  1 Reset, slot0 add x5<-x1,x2 -> prs1=1, prs2=2, prd=32, old_prd=5, count=31.
//  2 Pair x6<-x5+x5; x7<-x6+x1 -> slot1 prs1=prd of slot0 (32), slot1 prd=33, RAT[6]=32.
//  3 16 pairs writing x1..x31 without retire -> count 0, in_ready_o=0, no out change;
//    retire 2 pregs -> next cycle count=2, in_ready_o=1.
//  4 out_ready_i=0 three cycles with pair held -> out_* unchanged, in_ready_o=0, RAT frozen.
//  5 rd=x0 in slot0, store (regwrite=0) in slot1 -> both prd=0, count unchanged.
//  6 Same-cycle 2 allocs + 2 frees at head/tail wrap point -> count unchanged, pointers wrap to 0/1.

Source files
------------

// File: rtl/riscv_pkg.sv
// Shared rename/dispatch types: register-file sizes, register index typedefs and
// the request/response records passed between rename and dispatch.
package riscv_pkg;
  localparam int NUM_A_REGS = 32;
  localparam int NUM_P_REGS = 64;
  localparam int AW         = $clog2(NUM_A_REGS);
  localparam int PW         = $clog2(NUM_P_REGS);
  localparam int FL_DEPTH   = NUM_P_REGS - NUM_A_REGS;
  localparam int FL_PW      = $clog2(FL_DEPTH);
  localparam int FL_CW      = FL_PW + 1;

  typedef logic [AW-1:0] areg_t;
  typedef logic [PW-1:0] preg_t;

  typedef struct packed {
    logic  valid;
    areg_t rs1;
    areg_t rs2;
    areg_t rd;
    logic  regwrite;
  } rename_req_t;

  typedef struct packed {
    logic  valid;
    preg_t prs1;
    preg_t prs2;
    preg_t prd;
    preg_t old_prd;
  } rename_rsp_t;
endpackage

// File: rtl/rename_stage_free_list.sv
// Circular free list of physical registers: up to two pops from the head and two
// pushes at the tail per cycle, with an occupancy count.
module free_list
  import riscv_pkg::*;
(
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic [1:0]       pop_num_i,
  input  logic [1:0]       push_valid_i,
  input  preg_t [1:0]      push_preg_i,
  output preg_t [1:0]      head_preg_o,
  output logic [FL_CW-1:0] count_o
);
  preg_t            r_mem [FL_DEPTH];
  logic [FL_PW-1:0] r_head;
  logic [FL_PW-1:0] r_tail;
  logic [FL_CW-1:0] r_count;

  logic [1:0]       w_push;
  logic [1:0]       w_push_num;
  logic [FL_PW-1:0] w_head1;
  logic [FL_PW-1:0] w_tail1;
  logic [FL_CW:0]   w_count_next;

  // Releasing p0 is meaningless, so such pushes are dropped before they reach the tail
  assign w_push[0]    = push_valid_i[0] && (push_preg_i[0] != '0);
  assign w_push[1]    = push_valid_i[1] && (push_preg_i[1] != '0);
  assign w_push_num   = {1'b0, w_push[0]} + {1'b0, w_push[1]};
  assign w_head1      = r_head + FL_PW'(1);
  assign w_tail1      = r_tail + FL_PW'(w_push[0]);
  assign w_count_next = {1'b0, r_count} - (FL_CW+1)'(pop_num_i) + (FL_CW+1)'(w_push_num);

  assign head_preg_o[0] = r_mem[r_head];
  assign head_preg_o[1] = r_mem[w_head1];
  assign count_o        = r_count;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int i = 0; i < FL_DEPTH; i++) r_mem[i] <= preg_t'(NUM_A_REGS + i);
      r_head  <= '0;
      r_tail  <= '0;
      r_count <= FL_CW'(FL_DEPTH);
    end else begin
      assert (w_count_next <= (FL_CW+1)'(FL_DEPTH));
      if (w_push[0]) r_mem[r_tail]  <= push_preg_i[0];
      if (w_push[1]) r_mem[w_tail1] <= push_preg_i[1];
      r_head  <= r_head + FL_PW'(pop_num_i);
      r_tail  <= r_tail + FL_PW'(w_push_num);
      r_count <= w_count_next[FL_CW-1:0];
    end
  end
endmodule

// File: rtl/rename_stage.sv
// 2-wide register rename: RAT lookup with intra-pair bypass, destination allocation
// from free_list, and a registered output pair. RENAME_STATS_EN adds stat counters.
module rename_stage
  import riscv_pkg::*;
(
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic [1:0]   in_valid_i,
  output logic         in_ready_o,
  input  areg_t [1:0]  in_rs1_i,
  input  areg_t [1:0]  in_rs2_i,
  input  areg_t [1:0]  in_rd_i,
  input  logic [1:0]   in_regwrite_i,
  output logic [1:0]   out_valid_o,
  input  logic         out_ready_i,
  output preg_t [1:0]  out_prs1_o,
  output preg_t [1:0]  out_prs2_o,
  output preg_t [1:0]  out_prd_o,
  output preg_t [1:0]  out_old_prd_o,
  input  logic [1:0]   ret_valid_i,
`ifdef RENAME_STATS_EN
  input  preg_t [1:0]  ret_preg_i,
  output logic [31:0]  stat_renamed_o,
  output logic [31:0]  stat_stall_o
`else
  input  preg_t [1:0]  ret_preg_i
`endif
);
  preg_t             r_rat [NUM_A_REGS];
  rename_rsp_t [1:0] r_out;

  rename_req_t [1:0] w_req;
  rename_rsp_t [1:0] w_rsp;
  preg_t [1:0]       w_head_preg;
  logic [FL_CW-1:0]  w_count;
  logic [1:0]        w_need;
  logic [1:0]        w_pop_num;
  logic              w_accept;

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      w_req[s].valid    = in_valid_i[s];
      w_req[s].rs1      = in_rs1_i[s];
      w_req[s].rs2      = in_rs2_i[s];
      w_req[s].rd       = in_rd_i[s];
      w_req[s].regwrite = in_regwrite_i[s];
      w_need[s]         = in_valid_i[s] && in_regwrite_i[s] && (in_rd_i[s] != '0);
    end
  end

  assign in_ready_o = (!(r_out[0].valid || r_out[1].valid) || out_ready_i) &&
                      (w_count >= FL_CW'(2));
  assign w_accept   = in_ready_o && (|in_valid_i);
  assign w_pop_num  = w_accept ? ({1'b0, w_need[0]} + {1'b0, w_need[1]}) : 2'd0;

  free_list u_free_list (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .pop_num_i    (w_pop_num),
    .push_valid_i (ret_valid_i),
    .push_preg_i  (ret_preg_i),
    .head_preg_o  (w_head_preg),
    .count_o      (w_count)
  );

  // Slot1 is younger, so it sees slot0's fresh destination instead of the stale RAT entry
  always_comb begin
    w_rsp = '0;
    if (w_req[0].valid) begin
      w_rsp[0].valid = 1'b1;
      w_rsp[0].prs1  = (w_req[0].rs1 == '0) ? '0 : r_rat[w_req[0].rs1];
      w_rsp[0].prs2  = (w_req[0].rs2 == '0) ? '0 : r_rat[w_req[0].rs2];
      if (w_need[0]) begin
        w_rsp[0].prd     = w_head_preg[0];
        w_rsp[0].old_prd = r_rat[w_req[0].rd];
      end
    end
    if (w_req[1].valid) begin
      w_rsp[1].valid = 1'b1;
      if (w_req[1].rs1 == '0)                           w_rsp[1].prs1 = '0;
      else if (w_need[0] && w_req[1].rs1 == w_req[0].rd) w_rsp[1].prs1 = w_rsp[0].prd;
      else                                              w_rsp[1].prs1 = r_rat[w_req[1].rs1];
      if (w_req[1].rs2 == '0)                           w_rsp[1].prs2 = '0;
      else if (w_need[0] && w_req[1].rs2 == w_req[0].rd) w_rsp[1].prs2 = w_rsp[0].prd;
      else                                              w_rsp[1].prs2 = r_rat[w_req[1].rs2];
      if (w_need[1]) begin
        w_rsp[1].prd     = w_need[0] ? w_head_preg[1] : w_head_preg[0];
        w_rsp[1].old_prd = (w_need[0] && w_req[1].rd == w_req[0].rd) ? w_rsp[0].prd
                                                                      : r_rat[w_req[1].rd];
      end
    end
  end

  // Slot1's write is issued last so a shared rd ends up mapped to the younger allocation
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      for (int a = 0; a < NUM_A_REGS; a++) r_rat[a] <= preg_t'(a);
    end else if (w_accept) begin
      if (w_need[0]) r_rat[w_req[0].rd] <= w_rsp[0].prd;
      if (w_need[1]) r_rat[w_req[1].rd] <= w_rsp[1].prd;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_out <= '0;
    end else if (w_accept) begin
      r_out <= w_rsp;
    end else if (out_ready_i) begin
      r_out[0].valid <= 1'b0;
      r_out[1].valid <= 1'b0;
    end
  end

  always_comb begin
    for (int s = 0; s < 2; s++) begin
      out_valid_o[s]   = r_out[s].valid;
      out_prs1_o[s]    = r_out[s].prs1;
      out_prs2_o[s]    = r_out[s].prs2;
      out_prd_o[s]     = r_out[s].prd;
      out_old_prd_o[s] = r_out[s].old_prd;
    end
  end

`ifdef RENAME_STATS_EN
  logic [31:0] r_stat_renamed;
  logic [31:0] r_stat_stall;
  logic [31:0] w_nvalid;

  assign w_nvalid = 32'(in_valid_i[0]) + 32'(in_valid_i[1]);

  // Both counters stick at all-ones rather than wrapping
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      r_stat_renamed <= '0;
      r_stat_stall   <= '0;
    end else begin
      if (w_accept) begin
        if (r_stat_renamed > ('1 - w_nvalid)) r_stat_renamed <= '1;
        else                                  r_stat_renamed <= r_stat_renamed + w_nvalid;
      end
      if ((|in_valid_i) && !in_ready_o && (r_stat_stall != '1))
        r_stat_stall <= r_stat_stall + 32'd1;
    end
  end

  assign stat_renamed_o = r_stat_renamed;
  assign stat_stall_o   = r_stat_stall;
`endif
endmodule

// File: tb/tb_rename_stage.sv
// Self-checking bench for rename_stage: directed pairs with literal expectations,
// then randomized traffic compared each cycle against a sequential rename model.
module tb_rename_stage;
  import riscv_pkg::*;

  logic                 clk_i = 1'b0;
  logic                 rst_i;
  logic [1:0]           in_valid_i;
  logic                 in_ready_o;
  logic [1:0][AW-1:0]   in_rs1_i, in_rs2_i, in_rd_i;
  logic [1:0]           in_regwrite_i;
  logic [1:0]           out_valid_o;
  logic                 out_ready_i;
  logic [1:0][PW-1:0]   out_prs1_o, out_prs2_o, out_prd_o, out_old_prd_o;
  logic [1:0]           ret_valid_i;
  logic [1:0][PW-1:0]   ret_preg_i;
`ifdef RENAME_STATS_EN
  logic [31:0]          stat_renamed_o, stat_stall_o;
`endif

  rename_stage dut (
    .clk_i         (clk_i),
    .rst_i         (rst_i),
    .in_valid_i    (in_valid_i),
    .in_ready_o    (in_ready_o),
    .in_rs1_i      (in_rs1_i),
    .in_rs2_i      (in_rs2_i),
    .in_rd_i       (in_rd_i),
    .in_regwrite_i (in_regwrite_i),
    .out_valid_o   (out_valid_o),
    .out_ready_i   (out_ready_i),
    .out_prs1_o    (out_prs1_o),
    .out_prs2_o    (out_prs2_o),
    .out_prd_o     (out_prd_o),
    .out_old_prd_o (out_old_prd_o),
    .ret_valid_i   (ret_valid_i),
`ifdef RENAME_STATS_EN
    .ret_preg_i    (ret_preg_i),
    .stat_renamed_o(stat_renamed_o),
    .stat_stall_o  (stat_stall_o)
`else
    .ret_preg_i    (ret_preg_i)
`endif
  );

  always #5 clk_i = ~clk_i;

  // Reference model: architectural map, free FIFO, and the pair dispatch should see
  int   rat [NUM_A_REGS];
  int   fl [$];
  int   retq [$];
  logic [1:0] mValid;
  int   mPrs1 [2], mPrs2 [2], mPrd [2], mOld [2];
  int   total = 0;
  int   bad   = 0;

  task automatic checkVal(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  task automatic modelReset();
    for (int a = 0; a < NUM_A_REGS; a++) rat[a] = a;
    fl.delete();
    for (int i = 0; i < FL_DEPTH; i++) fl.push_back(NUM_A_REGS + i);
    retq.delete();
    mValid = 2'b00;
    for (int s = 0; s < 2; s++) begin
      mPrs1[s] = 0; mPrs2[s] = 0; mPrd[s] = 0; mOld[s] = 0;
    end
  endtask

  task automatic idleInputs();
    in_valid_i = 2'b00; in_rs1_i = '0; in_rs2_i = '0; in_rd_i = '0;
    in_regwrite_i = 2'b00; out_ready_i = 1'b1; ret_valid_i = 2'b00; ret_preg_i = '0;
  endtask

  task automatic setSlot(input int s, input bit v, input int rd, input int rs1,
                         input int rs2, input bit rw);
    in_valid_i[s]    = v;
    in_rd_i[s]       = AW'(rd);
    in_rs1_i[s]      = AW'(rs1);
    in_rs2_i[s]      = AW'(rs2);
    in_regwrite_i[s] = rw;
  endtask

  // Slots are renamed strictly in order; each sees the map as left by the older one
  task automatic modelStep();
    bit ready;
    ready = ((mValid == 2'b00) || out_ready_i) && (fl.size() >= 2);
    checkVal("in_ready", int'(in_ready_o), int'(ready));
    if (ready && in_valid_i != 2'b00) begin
      for (int s = 0; s < 2; s++) begin
        mPrs1[s] = 0; mPrs2[s] = 0; mPrd[s] = 0; mOld[s] = 0;
        if (in_valid_i[s]) begin
          mPrs1[s] = (in_rs1_i[s] == 0) ? 0 : rat[in_rs1_i[s]];
          mPrs2[s] = (in_rs2_i[s] == 0) ? 0 : rat[in_rs2_i[s]];
          if (in_regwrite_i[s] && in_rd_i[s] != 0) begin
            mOld[s] = rat[in_rd_i[s]];
            mPrd[s] = fl.pop_front();
            rat[in_rd_i[s]] = mPrd[s];
            retq.push_back(mOld[s]);
          end
        end
      end
      mValid = in_valid_i;
    end else if ((mValid == 2'b00) || out_ready_i) begin
      mValid = 2'b00;
    end
    for (int s = 0; s < 2; s++)
      if (ret_valid_i[s] && ret_preg_i[s] != 0) fl.push_back(int'(ret_preg_i[s]));
  endtask

  task automatic checkOutput();
    checkVal("out_valid", int'(out_valid_o), int'(mValid));
    for (int s = 0; s < 2; s++) begin
      if (mValid[s]) begin
        checkVal($sformatf("prs1[%0d]", s), int'(out_prs1_o[s]), mPrs1[s]);
        checkVal($sformatf("prs2[%0d]", s), int'(out_prs2_o[s]), mPrs2[s]);
        checkVal($sformatf("prd[%0d]", s), int'(out_prd_o[s]), mPrd[s]);
        checkVal($sformatf("old_prd[%0d]", s), int'(out_old_prd_o[s]), mOld[s]);
      end
    end
  endtask

  // Inputs are set just after a falling edge; this carries them across one rising edge
  task automatic applyStimulus();
    #1;
    modelStep();
    @(negedge clk_i);
    checkOutput();
  endtask

  task automatic doReset();
    idleInputs();
    rst_i = 1'b1;
    modelReset();
    repeat (2) @(negedge clk_i);
    rst_i = 1'b0;
    checkVal("reset_valid", int'(out_valid_o), 0);
    checkVal("reset_prd", int'(out_prd_o), 0);
    checkVal("reset_prs1", int'(out_prs1_o), 0);
    checkVal("reset_old_prd", int'(out_old_prd_o), 0);
    checkVal("reset_ready", int'(in_ready_o), 1);
  endtask

  task automatic randomCycle(input int cyc);
    int rd0;
    bit retireHeavy;
    idleInputs();
    in_valid_i    = 2'($urandom_range(0, 3));
    in_regwrite_i = 2'($urandom_range(0, 3));
    rd0 = $urandom_range(0, 31);
    setSlot(0, in_valid_i[0], rd0, $urandom_range(0, 31), $urandom_range(0, 31),
            in_regwrite_i[0]);
    setSlot(1, in_valid_i[1],
            ($urandom_range(0, 3) == 0) ? rd0 : $urandom_range(0, 31),
            ($urandom_range(0, 2) == 0) ? rd0 : $urandom_range(0, 31),
            ($urandom_range(0, 3) == 0) ? rd0 : $urandom_range(0, 31),
            in_regwrite_i[1]);
    out_ready_i = ($urandom_range(0, 3) != 0);
    retireHeavy = ((cyc % 400) < 250);
    for (int s = 0; s < 2; s++) begin
      if (retq.size() > 0 && (retireHeavy ? ($urandom_range(0, 3) != 0)
                                          : ($urandom_range(0, 7) == 0))) begin
        ret_valid_i[s] = 1'b1;
        ret_preg_i[s]  = PW'(retq.pop_front());
      end else if ($urandom_range(0, 9) == 0) begin
        ret_valid_i[s] = 1'b1;
        ret_preg_i[s]  = '0;
      end
    end
    applyStimulus();
  endtask

  initial begin
    idleInputs();
    rst_i = 1'b0;
    @(negedge clk_i);
    doReset();

    // Single add into x5 from the identity map
    idleInputs();
    setSlot(0, 1, 5, 1, 2, 1);
    applyStimulus();
    checkVal("t1_prs1", int'(out_prs1_o[0]), 1);
    checkVal("t1_prs2", int'(out_prs2_o[0]), 2);
    checkVal("t1_prd", int'(out_prd_o[0]), 32);
    checkVal("t1_old", int'(out_old_prd_o[0]), 5);

    // Dependent pair: slot1 reads x6 just produced by slot0
    idleInputs();
    setSlot(0, 1, 6, 5, 5, 1);
    setSlot(1, 1, 7, 6, 1, 1);
    applyStimulus();
    checkVal("t2_s0_prs1", int'(out_prs1_o[0]), 32);
    checkVal("t2_s0_prd", int'(out_prd_o[0]), 33);
    checkVal("t2_s1_prs1", int'(out_prs1_o[1]), 33);
    checkVal("t2_s1_prs2", int'(out_prs2_o[1]), 1);
    checkVal("t2_s1_prd", int'(out_prd_o[1]), 34);
    checkVal("t2_s1_old", int'(out_old_prd_o[1]), 7);

    // Accept x8, then stall dispatch for three cycles with a new pair waiting
    idleInputs();
    setSlot(0, 1, 8, 7, 0, 1);
    applyStimulus();
    checkVal("t4_prs2_x0", int'(out_prs2_o[0]), 0);
    checkVal("t4_prd", int'(out_prd_o[0]), 35);
    for (int k = 0; k < 3; k++) begin
      idleInputs();
      out_ready_i = 1'b0;
      setSlot(0, 1, 9, 1, 0, 1);
      #1;
      checkVal("t4_hold_ready", int'(in_ready_o), 0);
      applyStimulus();
      checkVal("t4_hold_prd", int'(out_prd_o[0]), 35);
      checkVal("t4_hold_valid", int'(out_valid_o), 1);
    end

    // rd=x0 and a store: neither allocates
    idleInputs();
    setSlot(0, 1, 0, 5, 0, 1);
    setSlot(1, 1, 3, 8, 6, 0);
    applyStimulus();
    checkVal("t5_s0_prd", int'(out_prd_o[0]), 0);
    checkVal("t5_s0_prs1", int'(out_prs1_o[0]), 32);
    checkVal("t5_s1_prd", int'(out_prd_o[1]), 0);
    checkVal("t5_s1_prs1", int'(out_prs1_o[1]), 35);
    checkVal("t5_s1_prs2", int'(out_prs2_o[1]), 33);
    idleInputs();
    setSlot(0, 1, 9, 1, 0, 1);
    applyStimulus();
    checkVal("t5_next_prd", int'(out_prd_o[0]), 36);
    checkVal("t5_next_old", int'(out_old_prd_o[0]), 9);

    // Drain the free list completely, then release two registers
    doReset();
    for (int k = 0; k < 16; k++) begin
      idleInputs();
      setSlot(0, 1, ((2 * k) % 31) + 1, k % 32, 0, 1);
      setSlot(1, 1, ((2 * k + 1) % 31) + 1, 0, k % 32, 1);
      applyStimulus();
    end
    checkVal("t3_last_prd", int'(out_prd_o[1]), 63);
    idleInputs();
    setSlot(0, 1, 4, 1, 2, 1);
    #1;
    checkVal("t3_full_ready", int'(in_ready_o), 0);
    applyStimulus();
    idleInputs();
    ret_valid_i = 2'b11;
    ret_preg_i[0] = PW'(retq.pop_front());
    ret_preg_i[1] = PW'(retq.pop_front());
    applyStimulus();
    idleInputs();
    setSlot(0, 1, 4, 1, 2, 1);
    setSlot(1, 1, 5, 4, 0, 1);
    #1;
    checkVal("t3_refill_ready", int'(in_ready_o), 1);
    applyStimulus();
    checkVal("t3_reuse_prd0", int'(out_prd_o[0]), 1);
    checkVal("t3_reuse_prd1", int'(out_prd_o[1]), 2);

    // Randomized traffic with an asynchronous reset in the middle
    doReset();
    for (int cyc = 0; cyc < 4000; cyc++) begin
      if (cyc == 2000) begin
        rst_i = 1'b1;
        #2;
        checkVal("async_reset_valid", int'(out_valid_o), 0);
        modelReset();
        idleInputs();
        @(negedge clk_i);
        rst_i = 1'b0;
        checkVal("async_reset_ready", int'(in_ready_o), 1);
      end
      randomCycle(cyc);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
